// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Decode-and-issue front end for the RV32I ALU. It accepts one OP or OP-IMM
//   instruction at a time, reads its operands from an internal 32x32 register
//   file, and drives funct3/funct7/operands to the ALU with a one-cycle enable.
//   It captures the ALU result one cycle later and writes it back to rd.
//   Any other opcode is consumed and reported with a one-cycle illegal pulse.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   instr_valid/ready    instruction handshake; transfer when both are high
//   instruction          RV32I instruction word
//   enable               ALU strobe, one cycle per legal instruction
//   funct3, funct7       ALU function select
//   register_data_1/2    ALU operands A (rs1) and B (rs2 or immediate)
//   register_data_out    ALU result, valid the cycle after enable
//   wb_valid/rd/data     one-cycle retire pulse with destination and value
//   illegal              one-cycle pulse for an unsupported opcode
//   dbg_addr, dbg_data   combinational register-file read port (x0 reads 0)
module alu_issue_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    output logic            enable,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] register_data_1,
    output logic [XLEN-1:0] register_data_2,
    input  logic [XLEN-1:0] register_data_out,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITEBACK,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t          state;
    state_t          state_next;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] rf [32];

    // Fields of the latched instruction.
    logic [6:0]      opcode_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [2:0]      f3_q;
    logic            is_r_type;
    logic            is_shift;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] operand_b;
    logic [6:0]      dec_funct7;
    logic            legal_in;
    logic            accept;
    logic            rf_we;

    assign opcode_q  = instr_q[6:0];
    assign rd_q      = instr_q[11:7];
    assign f3_q      = instr_q[14:12];
    assign rs1_q     = instr_q[19:15];
    assign rs2_q     = instr_q[24:20];

    // Only legal opcodes reach ISSUE/WAIT, so "not OP" there means OP-IMM.
    assign is_r_type = (opcode_q == OPC_OP);
    assign is_shift  = (f3_q == 3'b001) || (f3_q == 3'b101);

    assign rs1_val   = (rs1_q == 5'd0) ? '0 : rf[rs1_q];
    assign rs2_val   = (rs2_q == 5'd0) ? '0 : rf[rs2_q];
    assign imm_sext  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign operand_b = is_r_type ? rs2_val : imm_sext;

    // For non-shift immediates, bits 31:25 belong to the immediate; forcing
    // funct7 to zero keeps ADDI with a negative immediate from decoding as SUB.
    assign dec_funct7 = (is_r_type || is_shift) ? instr_q[31:25] : 7'b0000000;

    assign legal_in  = (instruction[6:0] == OPC_OP) || (instruction[6:0] == OPC_OP_IMM);
    assign accept    = instr_valid && instr_ready;
    assign rf_we     = (state == S_WRITEBACK) && (rd_q != 5'd0);

    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            // NOTE: the register file must read as zero after reset, so it is
            // cleared explicitly; this makes it flops rather than a RAM macro.
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                instr_q <= instruction;
            end
            if (state == S_WAIT) begin
                result_q <= register_data_out;
            end
            if (rf_we) begin
                rf[rd_q] <= result_q;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next      = state;
        instr_ready     = 1'b0;
        enable          = 1'b0;
        funct3          = 3'b000;
        funct7          = 7'b0000000;
        register_data_1 = '0;
        register_data_2 = '0;
        wb_valid        = 1'b0;
        wb_rd           = 5'd0;
        wb_data         = '0;
        illegal         = 1'b0;

        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = legal_in ? S_ISSUE : S_ILLEGAL;
                end
            end
            S_ISSUE: begin
                enable          = 1'b1;
                funct3          = f3_q;
                funct7          = dec_funct7;
                register_data_1 = rs1_val;
                register_data_2 = operand_b;
                state_next      = S_WAIT;
            end
            S_WAIT: begin
                // The register file cannot change here, so the bus stays stable.
                funct3          = f3_q;
                funct7          = dec_funct7;
                register_data_1 = rs1_val;
                register_data_2 = operand_b;
                state_next      = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                wb_valid   = 1'b1;
                wb_rd      = rd_q;
                wb_data    = (rd_q == 5'd0) ? '0 : result_q;
                state_next = S_IDLE;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit. A driver offers directed and random
// instructions; an architectural model of the register file predicts the ALU
// bus, the writeback and the illegal pulse for each accepted instruction and
// pushes them into scoreboard queues. A negedge monitor pops and compares
// whenever the DUT presents enable, wb_valid or illegal. A simple ALU
// responder answers enable with a result the following cycle.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        enable;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] register_data_1;
    logic [31:0] register_data_2;
    logic [31:0] register_data_out = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    alu_issue_unit #(.XLEN(32)) dut (
        .clock            (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .enable           (enable),
        .funct3           (funct3),
        .funct7           (funct7),
        .register_data_1  (register_data_1),
        .register_data_2  (register_data_2),
        .register_data_out(register_data_out),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .illegal          (illegal),
        .dbg_addr         (dbg_addr),
        .dbg_data         (dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Architectural reference
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
    } iss_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          acc;
    } wb_t;

    iss_t        iss_q[$];
    wb_t         wb_q[$];
    int          ill_q[$];
    logic [31:0] regs_m [32];
    int          ready_from = 0;

    // RV32I integer semantics; alt selects SUB / SRA.
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Called once per accepted instruction; acc is the cycle count right
    // after the accepting edge (the cycle in which ISSUE/ILLEGAL is shown).
    task automatic model_accept(input logic [31:0] ins, input int acc);
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  f7;
        logic        alt;
        logic [31:0] res;
        op = ins[6:0];
        rd = ins[11:7];
        f3 = ins[14:12];
        if (op == 7'h33 || op == 7'h13) begin
            a = regs_m[ins[19:15]];
            if (op == 7'h33) begin
                b   = regs_m[ins[24:20]];
                f7  = ins[31:25];
                alt = ins[30];
            end else begin
                b   = {{20{ins[31]}}, ins[31:20]};
                f7  = (f3 == 3'd1 || f3 == 3'd5) ? ins[31:25] : 7'd0;
                alt = (f3 == 3'd5) && ins[30];
            end
            res = golden(f3, alt, a, b);
            iss_q.push_back('{f3: f3, f7: f7, a: a, b: b, acc: acc});
            wb_q.push_back('{rd: rd, data: (rd == 5'd0) ? 32'd0 : res, acc: acc});
            if (rd != 5'd0) regs_m[rd] = res;
            ready_from = acc + 3;
        end else begin
            ill_q.push_back(acc);
            ready_from = acc + 1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor and ALU responder
    // ------------------------------------------------------------------
    bit          mon_on = 1'b0;
    bit          prev_en = 1'b0;
    logic [2:0]  hold_f3;
    logic [6:0]  hold_f7;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    iss_t        mi;
    wb_t         mw;
    int          mill;

    always @(negedge clk) begin
        if (mon_on) begin
            check("instr_ready", instr_ready, (cyc >= ready_from) ? 1'b1 : 1'b0);

            if (enable) begin
                if (iss_q.size() == 0) begin
                    check("enable_unexpected", enable, 1'b0);
                end else begin
                    mi = iss_q.pop_front();
                    check("issue_cycle", cyc, mi.acc);
                    check("issue_funct3", funct3, mi.f3);
                    check("issue_funct7", funct7, mi.f7);
                    check("issue_op_a", register_data_1, mi.a);
                    check("issue_op_b", register_data_2, mi.b);
                end
            end else if (prev_en) begin
                check("wait_hold_funct3", funct3, hold_f3);
                check("wait_hold_funct7", funct7, hold_f7);
                check("wait_hold_op_a", register_data_1, hold_a);
                check("wait_hold_op_b", register_data_2, hold_b);
            end else begin
                check("idle_bus_zero", {funct3, funct7, register_data_1[21:0]}, 32'd0);
                check("idle_bus_b_zero", register_data_2 | register_data_1, 32'd0);
            end

            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    mw = wb_q.pop_front();
                    check("wb_cycle", cyc, mw.acc + 2);
                    check("wb_rd", wb_rd, mw.rd);
                    check("wb_data", wb_data, mw.data);
                end
            end

            if (illegal) begin
                if (ill_q.size() == 0) begin
                    check("illegal_unexpected", illegal, 1'b0);
                end else begin
                    mill = ill_q.pop_front();
                    check("illegal_cycle", cyc, mill);
                end
            end
        end

        // ALU responder: result presented from mid-ISSUE through WAIT,
        // scrambled otherwise so a stale capture is visible.
        if (enable) begin
            register_data_out = golden(funct3, funct7[5], register_data_1, register_data_2);
        end else if (!prev_en) begin
            register_data_out = $urandom;
        end

        prev_en = enable;
        hold_f3 = funct3;
        hold_f7 = funct7;
        hold_a  = register_data_1;
        hold_b  = register_data_2;
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    // Entered at a negedge; offers ins until accepted; returns at the negedge
    // right after the accepting edge with instr_valid still high.
    task automatic issue(input logic [31:0] ins, output int acc);
        int waited;
        instruction = ins;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            check("ready_timeout", instr_ready, 1'b1);
            instr_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            @(posedge clk);
            model_accept(ins, acc);
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((iss_q.size() + wb_q.size() + ill_q.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", iss_q.size() + wb_q.size() + ill_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            dbg_addr = 5'(i);
            #1;
            check(name, dbg_data, regs_m[i]);
        end
    endtask

    task automatic dbg_expect(input string name, input logic [4:0] addr, input logic [31:0] exp);
        @(negedge clk);
        dbg_addr = addr;
        #1;
        check(name, dbg_data, exp);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [6:0]  op;
        int          kind;
        r    = $urandom;
        rd   = r[4:0];
        rs1  = r[9:5];
        rs2  = r[14:10];
        f3   = r[17:15];
        kind = $urandom_range(0, 9);
        if (kind < 4) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[18]) ? 7'h20 : 7'h00;
            return {f7, rs2, rs1, f3, rd, 7'h33};
        end else if (kind < 8) begin
            if (f3 == 3'd1)      imm = {7'h00, rs2};
            else if (f3 == 3'd5) imm = {r[18] ? 7'h20 : 7'h00, rs2};
            else                 imm = r[31:20];
            return {imm, rs1, f3, rd, 7'h13};
        end else begin
            op = r[31:25];
            if (op == 7'h33 || op == 7'h13) op = 7'h03;
            return {r[24:0], op};
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int acc1;
    int acc2;
    int acc3;

    initial begin
        for (int i = 0; i < 32; i++) regs_m[i] = '0;

        // Reset, then verify the idle state and a cleared register file.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        reset  = 1'b0;
        check("reset_ready", instr_ready, 1'b1);
        check("reset_enable", enable, 1'b0);
        check("reset_wb_valid", wb_valid, 1'b0);
        sweep("reset_rf_zero");

        // Directed sequence.
        @(negedge clk);
        issue(32'h00500093, acc1);  // ADDI x1,x0,5
        instr_valid = 1'b0;
        wait_drain();
        dbg_expect("x1_after_addi", 5'd1, 32'd5);

        issue(32'hFFD00113, acc1);  // ADDI x2,x0,-3
        instr_valid = 1'b0;
        issue(32'h402081B3, acc1);  // SUB x3,x1,x2
        instr_valid = 1'b0;
        issue(32'h40115213, acc1);  // SRAI x4,x2,1
        instr_valid = 1'b0;
        issue(32'h00700013, acc1);  // ADDI x0,x0,7
        instr_valid = 1'b0;
        wait_drain();
        dbg_expect("x3_after_sub", 5'd3, 32'd8);
        dbg_expect("x4_after_srai", 5'd4, 32'hFFFFFFFE);
        dbg_expect("x0_stays_zero", 5'd0, 32'd0);

        issue(32'h00002083, acc1);  // load: illegal
        instr_valid = 1'b0;
        wait_drain();
        sweep("rf_after_illegal");

        // Three ADDIs with instr_valid held high throughout.
        @(negedge clk);
        issue(32'h00100293, acc1);  // ADDI x5,x0,1
        issue(32'h00200313, acc2);  // ADDI x6,x0,2
        issue(32'h00300393, acc3);  // ADDI x7,x0,3
        instr_valid = 1'b0;
        check("burst_spacing_1", acc2 - acc1, 4);
        check("burst_spacing_2", acc3 - acc2, 4);
        wait_drain();

        // Reset during WAIT of the second of a held pair.
        issue(32'h00900413, acc1);  // ADDI x8,x0,9
        issue(32'h00A00493, acc2);  // ADDI x9,x0,10
        @(negedge clk);             // DUT now in WAIT for the second
        reset = 1'b1;
        iss_q.delete();
        wb_q.delete();
        ill_q.delete();
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        ready_from = cyc + 1;
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        check("ready_after_reset", instr_ready, 1'b1);
        repeat (3) @(negedge clk);
        sweep("rf_after_reset");

        // Random traffic, with idle gaps and junk offered while busy.
        @(negedge clk);
        for (int n = 0; n < 150; n++) begin
            issue(rand_instr(), acc1);
            if ($urandom_range(0, 2) == 0) begin
                instruction = $urandom;
                @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        instr_valid = 1'b0;
        wait_drain();
        sweep("rf_after_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
